paddle_motion_ctrl: RTL

//  Parametrised paddle position engine for the ping-pong game. Replaces the fixed-step paddle updater:

---
 rtl/paddle_motion_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/paddle_motion_ctrl.sv
// rtl/paddle_motion_ctrl.sv - per-player paddle position engine with frame-based acceleration
// Optional macro PADDLE_AUTO_TRACK_EN adds i_auto_en/i_target_y ball tracking.
module paddle_motion_ctrl #(
  parameter int COORD_W       = 10,
  parameter int X_INIT        = 0,
  parameter int Y_INIT        = 0,
  parameter int PADDLE_HEIGHT = 64,
  parameter int Y_MIN         = 0,
  parameter int Y_MAX         = 480,
  parameter int MIN_SPEED     = 1,
  parameter int MAX_SPEED     = 6,
  parameter int ACCEL_FRAMES  = 4
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_vsync_pulse,
  input  logic               i_move_up,
  input  logic               i_move_down,
`ifdef PADDLE_AUTO_TRACK_EN
  input  logic               i_auto_en,
  input  logic [COORD_W-1:0] i_target_y,
`endif
  output logic [COORD_W-1:0] o_paddle_x,
  output logic [COORD_W-1:0] o_paddle_y,
  output logic [3:0]         o_speed,
  output logic               o_moving,
  output logic               o_at_top,
  output logic               o_at_bottom
);

  localparam int Y_BOT = Y_MAX - PADDLE_HEIGHT;
  localparam int CNT_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;

  localparam logic [COORD_W:0]   Y_MIN_W  = (COORD_W+1)'(Y_MIN);
  localparam logic [COORD_W:0]   Y_BOT_W  = (COORD_W+1)'(Y_BOT);
  localparam logic [COORD_W-1:0] Y_MIN_C  = COORD_W'(Y_MIN);
  localparam logic [COORD_W-1:0] Y_BOT_C  = COORD_W'(Y_BOT);
  localparam logic [COORD_W-1:0] Y_INIT_C = COORD_W'(Y_INIT);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(ACCEL_FRAMES - 1);
  localparam logic [3:0]         SPD_MIN  = 4'(MIN_SPEED);
  localparam logic [3:0]         SPD_MAX  = 4'(MAX_SPEED);

  typedef enum logic [1:0] {ST_IDLE, ST_UP, ST_DOWN} state_e;
  typedef enum logic [1:0] {REQ_NONE, REQ_UP, REQ_DOWN} req_e;

  logic               up_meta_q, up_sync_q;
  logic               dn_meta_q, dn_sync_q;
  state_e             state_q, state_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic [3:0]         speed_q, speed_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  req_e               req;
  logic               move;
  logic [3:0]         step;

`ifdef PADDLE_AUTO_TRACK_EN
  localparam int ERR_W = COORD_W + 2;
  localparam logic signed [ERR_W-1:0] ERR_MIN  = ERR_W'(MIN_SPEED);
  localparam logic signed [ERR_W-1:0] HALF_PAD = ERR_W'(PADDLE_HEIGHT / 2);

  logic signed [ERR_W-1:0] err;
  logic [ERR_W-1:0]        abs_e;
  logic [3:0]              step_q, step_d;
`endif

  // Two-flop synchronisers; the FSM only ever looks at the *_sync_q copies.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      up_meta_q <= 1'b0;
      up_sync_q <= 1'b0;
      dn_meta_q <= 1'b0;
      dn_sync_q <= 1'b0;
    end else begin
      up_meta_q <= i_move_up;
      up_sync_q <= up_meta_q;
      dn_meta_q <= i_move_down;
      dn_sync_q <= dn_meta_q;
    end
  end

  always_comb begin
    req = REQ_NONE;
    if (up_sync_q && !dn_sync_q) begin
      req = REQ_UP;
    end else if (dn_sync_q && !up_sync_q) begin
      req = REQ_DOWN;
    end
`ifdef PADDLE_AUTO_TRACK_EN
    err   = $signed({2'b00, i_target_y}) - $signed({2'b00, y_q}) - HALF_PAD;
    abs_e = err[ERR_W-1] ? ERR_W'(-err) : ERR_W'(err);
    if (i_auto_en) begin
      req = REQ_NONE;
      if (err < -ERR_MIN) begin
        req = REQ_UP;
      end else if (err > ERR_MIN) begin
        req = REQ_DOWN;
      end
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    move    = 1'b0;
    step    = 4'd0;
    if (i_vsync_pulse) begin
      if (req == REQ_NONE) begin
        state_d = ST_IDLE;
        speed_d = 4'd0;
        cnt_d   = '0;
      end else if ((state_q == ST_UP && req == REQ_UP) ||
                   (state_q == ST_DOWN && req == REQ_DOWN)) begin
        move = 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (speed_q < SPD_MAX) begin
            speed_d = speed_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        // Starting from idle and reversing both restart the ramp.
        state_d = (req == REQ_UP) ? ST_UP : ST_DOWN;
        speed_d = SPD_MIN;
        cnt_d   = '0;
        move    = 1'b1;
      end
    end

    step = speed_d;
`ifdef PADDLE_AUTO_TRACK_EN
    if (i_auto_en && ({{(ERR_W-4){1'b0}}, step} > abs_e)) begin
      step = abs_e[3:0];
    end
`endif

    // Compare in COORD_W+1 bits so a clamp decision never sees a wrapped value.
    if (move) begin
      if (req == REQ_UP) begin
        if ({1'b0, y_q} < Y_MIN_W + (COORD_W+1)'(step)) begin
          y_d = Y_MIN_C;
        end else begin
          y_d = y_q - COORD_W'(step);
        end
      end else begin
        if ({1'b0, y_q} + (COORD_W+1)'(step) > Y_BOT_W) begin
          y_d = Y_BOT_C;
        end else begin
          y_d = y_q + COORD_W'(step);
        end
      end
    end
  end

`ifdef PADDLE_AUTO_TRACK_EN
  always_comb begin
    step_d = step_q;
    if (i_vsync_pulse) begin
      step_d = move ? step : 4'd0;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      step_q <= 4'd0;
    end else begin
      step_q <= step_d;
    end
  end

  assign o_speed = step_q;
`else
  assign o_speed = speed_q;
`endif

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      y_q     <= Y_INIT_C;
      speed_q <= 4'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      speed_q <= speed_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_paddle_x  = COORD_W'(X_INIT);
  assign o_paddle_y  = y_q;
  assign o_moving    = (state_q != ST_IDLE);
  assign o_at_top    = (y_q == Y_MIN_C);
  assign o_at_bottom = (y_q == Y_BOT_C);

endmodule
